// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: radix-4 Booth multiply (WIDTH/2+1 steps) and
// non-restoring divide on magnitudes (WIDTH steps plus one sign-fix step).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    acc_reg, mcand_reg, booth_pp, acc_next;
    logic [WIDTH+1:0] mplier_reg;
    logic             mplier_prev_reg;
    logic [WIDTH:0]   rem_reg, rem_shift, rem_step;
    logic [WIDTH-1:0] quo_reg, dvsr_reg, quo_step, rem_mag, quo_final, rem_final;
    logic             neg_q_reg, neg_r_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             dbz_reg;
    logic             a_neg, b_neg, b_zero, mul_last, div_last;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg  = op_signed & A[WIDTH-1];
    assign b_neg  = op_signed & B[WIDTH-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;
    assign b_zero = (B == '0);

    assign mul_last = (cnt_reg == CW'(WIDTH / 2));
    assign div_last = (cnt_reg == CW'(WIDTH - 1));

    // Booth digit from the current bit pair plus the bit shifted out last step
    always_comb begin
        booth_pp = '0;
        case ({mplier_reg[1:0], mplier_prev_reg})
            3'b001, 3'b010: booth_pp = mcand_reg;
            3'b011:         booth_pp = mcand_reg << 1;
            3'b100:         booth_pp = -(mcand_reg << 1);
            3'b101, 3'b110: booth_pp = -mcand_reg;
            default:        booth_pp = '0;
        endcase
    end
    assign acc_next = acc_reg + booth_pp;

    // The shifted remainder may wrap, but every post-add result lies in [-d, d)
    assign rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    assign rem_step  = rem_reg[WIDTH] ? rem_shift + {1'b0, dvsr_reg}
                                      : rem_shift - {1'b0, dvsr_reg};
    assign quo_step  = {quo_reg[WIDTH-2:0], ~rem_step[WIDTH]};
    assign rem_mag   = rem_reg[WIDTH] ? rem_reg[WIDTH-1:0] + dvsr_reg : rem_reg[WIDTH-1:0];
    assign quo_final = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_final = neg_r_reg ? -rem_mag : rem_mag;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = !op_div ? MUL : (b_zero ? DONE : DIV);
            MUL:  if (mul_last) state_next = DONE;
            DIV:  if (div_last) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc_reg         <= '0;
            mcand_reg       <= '0;
            mplier_reg      <= '0;
            mplier_prev_reg <= 1'b0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            dvsr_reg        <= '0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            cnt_reg         <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            dbz_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    cnt_reg         <= '0;
                    acc_reg         <= '0;
                    mcand_reg       <= {{WIDTH{a_neg}}, A};
                    mplier_reg      <= {{2{b_neg}}, B};
                    mplier_prev_reg <= 1'b0;
                    rem_reg         <= '0;
                    quo_reg         <= a_mag;
                    dvsr_reg        <= b_mag;
                    neg_q_reg       <= a_neg ^ b_neg;
                    neg_r_reg       <= a_neg;
                    if (op_div && b_zero) begin
                        hi_reg  <= A;
                        lo_reg  <= '1;
                        dbz_reg <= 1'b1;
                    end
                end
                MUL: begin
                    acc_reg         <= acc_next;
                    mcand_reg       <= mcand_reg << 2;
                    mplier_reg      <= {2'b00, mplier_reg[WIDTH+1:2]};
                    mplier_prev_reg <= mplier_reg[1];
                    cnt_reg         <= cnt_reg + CW'(1);
                    if (mul_last) begin
                        hi_reg  <= acc_next[PW-1:WIDTH];
                        lo_reg  <= acc_next[WIDTH-1:0];
                        dbz_reg <= 1'b0;
                    end
                end
                DIV: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                FIX: begin
                    hi_reg  <= rem_final;
                    lo_reg  <= quo_final;
                    dbz_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign div_by_zero = dbz_reg;
    assign HI          = hi_reg;
    assign LO          = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expectations queued at issue, popped on done.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear_n, start, op_div, op_signed;
    logic [W-1:0] A, B, HI, LO;
    logic         busy, done, div_by_zero;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .op_div(op_div),
        .op_signed(op_signed), .A(A), .B(B), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int txn = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        int           e0;
    } exp_t;

    typedef struct packed {
        logic         d;
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic d, input logic s, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        e.e0  = 0;
        e.dbz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!d) begin
            if (s) p = 64'(sa * sb);
            else   p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = W / 2 + 2;
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = W + 2;
            if (s) begin
                q = sa / sb;
                r = sa % sb;
                e.lo = q[31:0];
                e.hi = r[31:0];
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued expectation
    always @(negedge clock) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d: HI=%h LO=%h dbz=%0b latency=%0d (exp HI=%h LO=%h dbz=%0b latency=%0d)",
                         txn, HI, LO, div_by_zero, edge_cnt - e.e0 + 1, e.hi, e.lo, e.dbz, e.lat);
                check("hi", 64'(HI), 64'(e.hi));
                check("lo", 64'(LO), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("latency", 64'(edge_cnt - e.e0 + 1), 64'(e.lat));
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input logic d, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e);
        int i;
        e.e0 = edge_cnt + 1;
        sb_q.push_back(e);
        op_div = d; op_signed = s; A = a; B = b; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        if (e.lat > 2) begin
            // Conflicting request while busy must be ignored
            @(negedge clock);
            start = 1'b1; op_div = ~d; A = ~a; B = '0;
            @(negedge clock);
            start = 1'b0;
        end
        for (i = 0; i < 100 && done !== 1'b1; i++) @(negedge clock);
        if (done !== 1'b1) begin
            check("timeout", 64'(0), 64'(1));
        end else begin
            // Request presented during DONE must be ignored too
            start = 1'b1; op_div = 1'b1; A = 32'h1234_5678; B = '0;
            @(negedge clock);
            start = 1'b0;
            check("idle_after_done", 64'(busy), 64'(0));
        end
    endtask

    vec_t vecs[7];

    initial begin : stim
        exp_t         e;
        logic         d, s;
        logic [W-1:0] a, b;
        int           done_seen;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 18};
        vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 18};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 18};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[4] = '{1'b1, 1'b0, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 34};
        vecs[5] = '{1'b1, 1'b0, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[6] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};

        clear_n = 1'b0; start = 1'b0; op_div = 1'b0; op_signed = 1'b0; A = '0; B = '0;
        #3;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        check("rst_hi", 64'(HI), 64'(0));
        check("rst_lo", 64'(LO), 64'(0));
        repeat (3) @(negedge clock);
        clear_n = 1'b1;

        // First op is issued in the same cycle reset is released
        foreach (vecs[k]) begin
            e.hi = vecs[k].hi; e.lo = vecs[k].lo; e.dbz = vecs[k].dbz; e.lat = vecs[k].lat;
            run_op(vecs[k].d, vecs[k].s, vecs[k].a, vecs[k].b, e);
        end

        for (int n = 0; n < 24; n++) begin
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = (n % 6 == 0) ? 32'h8000_0000 : 32'($urandom);
            case (n % 4)
                0:       b = 32'($urandom_range(1, 255));
                1:       b = -32'($urandom_range(1, 255));
                2:       b = (n % 8 == 2) ? 32'd0 : 32'($urandom);
                default: b = 32'($urandom);
            endcase
            run_op(d, s, a, b, model(d, s, a, b));
        end

        // Abort a divide at iteration 10
        op_div = 1'b1; op_signed = 1'b0; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        check("busy_mid_div", 64'(busy), 64'(1));
        clear_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_dbz", 64'(div_by_zero), 64'(0));
        check("abort_hi", 64'(HI), 64'(0));
        check("abort_lo", 64'(LO), 64'(0));
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        check("no_done_after_abort", 64'(done_seen), 64'(0));
        check("idle_after_abort", 64'(busy), 64'(0));

        run_op(1'b1, 1'b0, 32'd1000, 32'd3, model(1'b1, 1'b0, 32'd1000, 32'd3));
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000,
               model(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000));

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; even, >= 4.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request an operation, sampled only in IDLE.
REQ-005 SHALL have port op_div, input, 1: 0 = multiply, 1 = divide; sampled with start.
REQ-006 SHALL have port op_signed, input, 1: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port A, input, WIDTH: multiplicand or dividend; sampled with start.
REQ-008 SHALL have port B, input, WIDTH: multiplier or divisor; sampled with start.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse; HI/LO valid from this cycle.
REQ-011 SHALL have port div_by_zero, output, 1: set with done when op_div=1 and B=0; otherwise cleared with done.
REQ-012 SHALL have port HI, output, WIDTH: product upper half, or remainder.
REQ-013 SHALL have port LO, output, WIDTH: product lower half, or quotient.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-015 SHALL register A, B, op_div and op_signed at the edge sampling start=1 in IDLE (edge E0).
REQ-016 SHALL ignore start in every state other than IDLE, including DONE.
REQ-017 SHALL leave IDLE at E0 as follows: to MUL if op_div=0; to DIV if op_div=1 and B!=0; straight to DONE if op_div=1 and B=0.
REQ-018 Multiply SHALL use radix-4 Booth recoding, one bit-pair per edge.
REQ-019 Multiply SHALL extend the multiplier to WIDTH+2 bits: sign-extend when op_signed=1, zero-extend when op_signed=0.
REQ-020 Multiply SHALL run exactly WIDTH/2+1 iteration edges, then move to DONE, giving the full 2*WIDTH-bit product.
REQ-021 Divide SHALL use non-restoring division on operand magnitudes (magnitudes only when op_signed=1), a WIDTH+1-bit partial remainder and WIDTH iteration edges, then move to FIX.
REQ-022 FIX SHALL take one edge: restore a negative remainder by adding the divisor, then apply signs, then move to DONE.
REQ-023 Signed division SHALL truncate the quotient toward zero; the remainder SHALL take the dividend's sign.
REQ-024 Signed most-negative / -1 SHALL give quotient = most-negative value (wrap) and remainder 0, with no flag.
REQ-025 Divide-by-zero SHALL give HI = A, LO = all ones and div_by_zero = 1.
REQ-026 SHALL load HI/LO on the edge entering DONE and hold them until the next entry to DONE.
REQ-027 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-028 done SHALL be visible after the following edge, counting E0 as edge 1:
- multiply: edge WIDTH/2+2;
- divide: edge WIDTH+2;
- divide-by-zero: edge 1.
REQ-029 A start in the cycle after done (state IDLE) SHALL be accepted, giving back-to-back operations with one idle cycle minimum.

Reset
REQ-030 While clear_n=0, the block SHALL immediately force state IDLE and busy=0, done=0, div_by_zero=0, HI=0, LO=0, regardless of clock.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge with clear_n=1.

Verification (WIDTH=32)
REQ-033 Signed multiply 7 * -3 -> HI=FFFFFFFF, LO=FFFFFFEB, done after edge 18.
REQ-034 Unsigned multiply FFFFFFFF * FFFFFFFF -> HI=FFFFFFFE, LO=00000001; the same operands signed -> HI=00000000, LO=00000001.
REQ-035 Signed divide -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF, done after edge 34; unsigned 100 / 7 -> LO=0000000E, HI=00000002.
REQ-036 Divide 5 / 0 -> HI=00000005, LO=FFFFFFFF, div_by_zero=1, done after edge 1.
REQ-037 Signed 80000000 / FFFFFFFF -> LO=80000000, HI=00000000, div_by_zero=0.
REQ-038 Reset and ignored start:
- clear_n pulsed low at DIV iteration 10 -> busy, done, HI and LO at 0 at once, no done pulse;
- start pulsed during busy -> ignored, result unchanged.
